// File: rtl/synth_pkg.sv
// Shared types for the synth voice and its note sequencer.
package synth_pkg;
  localparam int OSC_W = 12;

  typedef enum logic {IDLE, RUN} seq_state_t;

  typedef struct packed {
    logic             gate;
    logic [OSC_W-1:0] count;
  } seq_entry_t;
endpackage

// File: rtl/seq_pattern_mem.sv
// Flop-based pattern store: synchronous clear, one write port, combinational
// read with write bypass so a step loaded on the write edge sees the new data.
module seq_pattern_mem
  import synth_pkg::*;
#(
  parameter int STEPS = 8,
  localparam int AW = $clog2(STEPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  seq_entry_t    wr_data,
  input  logic [AW-1:0] rd_addr,
  output seq_entry_t    rd_data
);
  seq_entry_t mem [STEPS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STEPS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = mem[rd_addr];
    if (wr_en && (wr_addr == rd_addr)) rd_data = wr_data;
  end
endmodule

// File: rtl/note_sequencer.sv
// Step sequencer driving synth trig/osc_count from an up-to-STEPS pattern.
// All outputs registered; tempo, gate length and last step are read live.
module note_sequencer
  import synth_pkg::*;
#(
  parameter int STEPS = 8,
  parameter int CNT_W = 24,
  localparam int AW = $clog2(STEPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] tempo_div,
  input  logic [CNT_W-1:0] gate_len,
  input  logic [AW-1:0]    last_step,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [OSC_W-1:0] wr_count,
  input  logic             wr_gate,
  output logic             trig,
  output logic [OSC_W-1:0] osc_count,
  output logic [AW-1:0]    step,
  output logic             step_stb
);
  seq_state_t       state, state_nxt;
  logic [CNT_W-1:0] tick;
  logic             gate_flag;

  logic [CNT_W-1:0] eff_div, eff_m1, gate_lim, tick_nxt;
  logic             start;
  logic [AW-1:0]    ld_step;
  seq_entry_t       wr_data, rd_data;

  assign wr_data = '{gate: wr_gate, count: wr_count};

  seq_pattern_mem #(.STEPS(STEPS)) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (ld_step),
    .rd_data (rd_data)
  );

  // The last tick of each step is always low so back-to-back gates retrigger.
  always_comb begin
    eff_div  = (tempo_div < CNT_W'(2)) ? CNT_W'(2) : tempo_div;
    eff_m1   = eff_div - CNT_W'(1);
    gate_lim = (gate_len < eff_m1) ? gate_len : eff_m1;
    tick_nxt = tick + CNT_W'(1);
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    ld_step   = '0;
    case (state)
      IDLE: if (en) begin
        state_nxt = RUN;
        start     = 1'b1;
      end
      RUN: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (tick >= eff_m1) begin
          start   = 1'b1;
          ld_step = (step >= last_step) ? '0 : step + AW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tick      <= '0;
      gate_flag <= 1'b0;
      trig      <= 1'b0;
      osc_count <= '0;
      step      <= '0;
      step_stb  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        step      <= ld_step;
        osc_count <= rd_data.count;
        gate_flag <= rd_data.gate;
        tick      <= '0;
        step_stb  <= 1'b1;
        trig      <= rd_data.gate && (gate_lim != '0);
      end else if (state == RUN && en) begin
        tick     <= tick_nxt;
        step_stb <= 1'b0;
        trig     <= gate_flag && (tick_nxt < gate_lim);
      end else begin
        tick     <= '0;
        step_stb <= 1'b0;
        trig     <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with a step-level reference model feeding
// an expected-output queue that is drained one entry per clock.
module tb_note_sequencer;
  localparam int STEPS = 8;
  localparam int CNT_W = 24;
  localparam int AW = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic [CNT_W-1:0] tempo_div = 24'd10;
  logic [CNT_W-1:0] gate_len = 24'd4;
  logic [AW-1:0]    last_step = 3'd3;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [11:0]      wr_count = '0;
  logic             wr_gate = 1'b0;
  logic             trig;
  logic [11:0]      osc_count;
  logic [AW-1:0]    step;
  logic             step_stb;

  note_sequencer #(.STEPS(STEPS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .tempo_div(tempo_div), .gate_len(gate_len),
    .last_step(last_step), .wr_en(wr_en), .wr_addr(wr_addr), .wr_count(wr_count),
    .wr_gate(wr_gate), .trig(trig), .osc_count(osc_count), .step(step),
    .step_stb(step_stb)
  );

  always #24 clk = ~clk;

  typedef struct {
    logic        trig;
    logic [11:0] osc;
    logic [2:0]  step;
    logic        stb;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  // reference model state
  int m_cnt [STEPS];
  int m_gate[STEPS];
  int m_run = 0, m_step = 0, m_tick = 0, m_gflag = 0, m_osc = 0, m_trig = 0, m_stb = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic m_start(input int s, input int lim);
    m_step = s; m_osc = m_cnt[s]; m_gflag = m_gate[s];
    m_tick = 0; m_stb = 1; m_trig = (m_gflag != 0 && lim > 0) ? 1 : 0;
  endtask

  // Advance the model across one edge using the inputs as they are now.
  task automatic model_edge();
    int eff, lim;
    exp_t e;
    eff = (tempo_div < 2) ? 2 : int'(tempo_div);
    lim = (int'(gate_len) < eff - 1) ? int'(gate_len) : eff - 1;
    if (rst) begin
      for (int i = 0; i < STEPS; i++) begin m_cnt[i] = 0; m_gate[i] = 0; end
      m_run = 0; m_step = 0; m_tick = 0; m_gflag = 0; m_osc = 0; m_trig = 0; m_stb = 0;
    end else begin
      if (wr_en) begin m_cnt[wr_addr] = wr_count; m_gate[wr_addr] = wr_gate; end
      if (!m_run) begin
        if (en) begin m_run = 1; m_start(0, lim); end
        else begin m_trig = 0; m_stb = 0; end
      end else if (!en) begin
        m_run = 0; m_trig = 0; m_stb = 0; m_tick = 0;
      end else if (m_tick >= eff - 1) begin
        m_start((m_step >= int'(last_step)) ? 0 : m_step + 1, lim);
      end else begin
        m_tick++; m_stb = 0;
        m_trig = (m_gflag != 0 && m_tick < lim) ? 1 : 0;
      end
    end
    e.trig = m_trig[0]; e.osc = m_osc[11:0]; e.step = m_step[2:0]; e.stb = m_stb[0];
    q.push_back(e);
  endtask

  task automatic cyc();
    exp_t e;
    model_edge();
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("trig", trig, e.trig);
    chk("osc_count", osc_count, e.osc);
    chk("step", step, e.step);
    chk("step_stb", step_stb, e.stb);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wr(input int a, input int c, input int g);
    wr_en = 1'b1; wr_addr = a[2:0]; wr_count = c[11:0]; wr_gate = g[0];
    cyc();
    wr_en = 1'b0;
  endtask

  // Run until a step start (optionally of step s); a missed bound is a failure.
  task automatic wait_step(input int s);
    bit hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      cyc();
      if (step_stb && (s < 0 || int'(step) == s)) hit = 1;
    end
    chk("wait_step_timeout", hit, 1);
  endtask

  initial begin
    int ones;
    for (int i = 0; i < STEPS; i++) begin m_cnt[i] = 0; m_gate[i] = 0; end

    // reset and idle
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(100);
    chk("idle_trig", trig, 0);
    chk("idle_osc", osc_count, 0);
    chk("idle_step", step, 0);
    chk("idle_stb", step_stb, 0);

    // basic run
    for (int i = 0; i < 4; i++) wr(i, 100 * (i + 1), 1);
    last_step = 3'd3; tempo_div = 24'd10; gate_len = 24'd4;
    en = 1'b1;
    cyc();
    chk("start_step", step, 0);
    chk("start_osc", osc_count, 100);
    chk("start_stb", step_stb, 1);
    chk("start_trig", trig, 1);
    cycles(9);
    chk("step1_stb_period", step_stb, 0);
    cyc();
    chk("step1_stb", step_stb, 1);
    chk("step1_osc", osc_count, 200);
    cycles(35);

    // long gate: 9 high, 1 low per step
    gate_len = 24'd50;
    wait_step(-1);
    ones = trig;
    for (int i = 0; i < 9; i++) begin cyc(); ones += trig; end
    chk("long_gate_high_cycles", ones, 9);
    cyc();
    chk("long_gate_retrigger", trig, 1);

    // silent step 2 still loads its pitch
    gate_len = 24'd4;
    wr(2, 300, 0);
    wait_step(2);
    chk("silent_osc", osc_count, 300);
    ones = trig;
    for (int i = 0; i < 9; i++) begin cyc(); ones += trig; end
    chk("silent_trig_cycles", ones, 0);

    // degenerate tempo: 2-cycle steps
    tempo_div = 24'd0;
    wait_step(1);
    chk("fast_trig_hi", trig, 1);
    cyc();
    chk("fast_trig_lo", trig, 0);
    cyc();
    chk("fast_stb_period", step_stb, 1);
    cycles(10);
    tempo_div = 24'd10;

    // live write to the playing step
    wait_step(1);
    cyc();
    wr(1, 555, 1);
    cyc();
    chk("live_wr_no_effect", osc_count, 200);
    wait_step(1);
    chk("live_wr_next_visit", osc_count, 555);

    // lower last_step while on step 3
    wait_step(3);
    last_step = 3'd1;
    wait_step(-1);
    chk("wrap_after_lowered_last", step, 0);
    last_step = 3'd3;
    cycles(5);

    // stop at tick 2 of step 2, then restart
    wr(2, 300, 1);
    wait_step(2);
    cycles(2);
    en = 1'b0;
    cyc();
    chk("stop_trig", trig, 0);
    chk("stop_stb", step_stb, 0);
    cycles(5);
    en = 1'b1;
    cyc();
    chk("restart_step", step, 0);
    chk("restart_stb", step_stb, 1);
    cycles(15);

    // reset mid-run clears outputs and memory
    rst = 1'b1;
    cyc();
    chk("rst_trig", trig, 0);
    chk("rst_osc", osc_count, 0);
    chk("rst_step", step, 0);
    chk("rst_stb", step_stb, 0);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      chk("rst_mem_zero_osc", osc_count, 0);
      chk("rst_mem_zero_trig", trig, 0);
    end
    en = 1'b0;
    cycles(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
